// File: rtl/rc4_xor_stream.sv
// RC4 keystream XOR stage: sequences the keystream generator per key session, then
// XORs each accepted plaintext byte with the next unused keystream byte (1-cycle latency).
module rc4_xor_stream #(
  parameter int NUMS_OF_BYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  output logic                       gen_rst_n,
  output logic                       gen_start,
  input  logic                       gen_done,
  input  logic [NUMS_OF_BYTES*8-1:0] gen_ckey,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       exhausted
);

  localparam int IDX_W = $clog2(NUMS_OF_BYTES) + 1;
  localparam int SEL_W = (NUMS_OF_BYTES > 1) ? $clog2(NUMS_OF_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMS_OF_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRST    = 3'd1,
    WAIT_KS = 3'd2,
    STREAM  = 3'd3,
    DRAIN   = 3'd4,
    EXHAUST = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic             armed_q, armed_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       ks_q [NUMS_OF_BYTES];
  logic [7:0]       ks_d [NUMS_OF_BYTES];
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             accept;
  logic [SEL_W-1:0] sel;

  assign sel       = idx_q[SEL_W-1:0];
  assign in_ready  = ~rst & (state_q == STREAM) & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign gen_rst_n = ~rst & (state_q != GRST);
  assign gen_start = ~rst & (state_q == WAIT_KS);
  assign exhausted = ~rst & (state_q == EXHAUST);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    idx_d       = idx_q;
    ks_d        = ks_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (accept) begin
      out_data_d  = in_data ^ ks_q[sel];
      out_valid_d = 1'b1;
      out_last_d  = (idx_q == LAST_IDX);
      idx_d       = idx_q + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE, EXHAUST: if (go) state_d = GRST;
      GRST: begin
        state_d = WAIT_KS;
        armed_d = 1'b0;
      end
      WAIT_KS: begin
        // done is only trusted from the second cycle, after the generator saw its reset
        armed_d = 1'b1;
        if (armed_q && gen_done) begin
          state_d = STREAM;
          idx_d   = '0;
          for (int b = 0; b < NUMS_OF_BYTES; b++) ks_d[b] = gen_ckey[b*8 +: 8];
        end
      end
      STREAM: if (accept && (idx_q == LAST_IDX)) state_d = DRAIN;
      DRAIN:  if (!out_valid_q) state_d = EXHAUST;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      idx_q       <= '0;
      for (int b = 0; b < NUMS_OF_BYTES; b++) ks_q[b] <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      idx_q       <= idx_d;
      ks_q        <= ks_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule
